pe_seq_ctrl: RTL and testbench
==============================

Name: pe_seq_ctrl

Overview:
Sequencer that drives the control and operand side of one weight-stationary MAC processing element and collects its result. It accepts dot-product jobs and an operand stream, then generates the PE's act/wgt/store/reuse/addr/finish signals. It captures the PE's running-accumulator output and returns the per-job dot product on a valid/ready result port. It sits between the array scheduler and each PE.

Parameters:
IN_PRECISION, 16, operand width; matches PE.
OUT_PRECISION, 32, accumulator/result width; matches PE.
REG_SIZE, 4, PE register-file depth; entry 0 is the PE accumulator, entries 1..REG_SIZE-1 hold weights.
LEN_W, 8, job length width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
job_valid  in  1  job offered
job_ready  out  1  controller idle, job accepted when both high
job_mode  in  2  0=STREAM, 1=LOAD, 2=REUSE, 3=reserved (treated as STREAM)
job_len  in  LEN_W  beats in job
op_valid  in  1  operand beat offered
op_ready  out  1  beat accepted when both high
op_act  in  IN_PRECISION  activation
op_wgt  in  IN_PRECISION  weight
pe_act  out  IN_PRECISION  to PE act
pe_wgt  out  IN_PRECISION  to PE wgt
pe_store  out  1  to PE store
pe_reuse  out  1  to PE reuse
pe_addr  out  REG_SIZE  to PE addr
pe_finish  out  1  to PE finish
pe_out  in  OUT_PRECISION  from PE out
res_valid  out  1  result available
res_ready  in  1  result consumed when both high
res_data  out  OUT_PRECISION  dot product of last STREAM/REUSE job

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. The PE shares the same rst.
- All pe_* and res_* outputs are registered. On reset:
  - pe_* = 0.
  - res_valid = 0, res_data = 0.
  - job_ready = 1, op_ready = 0.
  - base = 0, state = IDLE.
- Reset mid-job aborts the job with no result.
- The PE accumulator is never cleared between jobs. The controller keeps a base register equal to the last captured pe_out. It reports res_data = pe_out - base, modulo 2^OUT_PRECISION, then sets base to pe_out.
- Outside an accepted beat, pe_act = 0, pe_wgt = 0, pe_store = 0, pe_reuse = 0. The PE therefore adds 0 each idle or bubble cycle. pe_addr holds its value.
- States:
  - IDLE: job_ready = 1. On job accept, latch mode and length and set idx = 1.
    - len = 0: go to FIN, or to IDLE if mode is LOAD.
    - Otherwise go to RUN.
  - RUN: op_ready = 1 and job_ready = 0. Each accepted beat drives the PE on the next cycle:
    - STREAM: pe_act = op_act, pe_wgt = op_wgt, reuse = 0.
    - LOAD: pe_store = 1, pe_addr = idx, pe_wgt = op_wgt, pe_act = 0. The act is forced to 0 so the concurrent PE MAC adds nothing.
    - REUSE: pe_reuse = 1, pe_addr = idx, pe_act = op_act. op_wgt is ignored.
    - idx runs 1..REG_SIZE-1 and wraps to 1. Address 0 is never driven with store or reuse.
    - LOAD length is clipped to REG_SIZE-1. Beats beyond that are not requested.
    - At most one beat per cycle. A cycle with op_valid = 0 is a zero bubble.
    - After the last beat: LOAD goes to IDLE; other modes go to FIN.
  - FIN: one cycle with pe_finish = 1 and zero operands. The PE samples its accumulator, which includes the last MAC applied one edge earlier. Go to CAP.
  - CAP: one cycle. pe_out is now valid. Compute res_data, update base, set res_valid = 1, go to RES.
  - RES: hold res_data and res_valid until res_ready. Then clear res_valid and go to IDLE.
- Latency:
  - Last beat accepted at edge t gives res_valid at edge t+4.
  - A job of N beats with no stalls takes N+4 cycles from job accept to result; the job is then accepted again when res_ready is high.
- Arithmetic: widths follow the PE. Result wraps modulo 2^OUT_PRECISION.

Optional Feature:
PE_SEQ_CTRL_PERF_EN
- Defined:
  - Adds outputs perf_busy[31:0], which counts cycles with state != IDLE.
  - Adds perf_stall[31:0], which counts RUN cycles with op_valid = 0 plus RES cycles with res_ready = 0.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- STREAM len=3, beats (2,3), (4,5), (1,7) -> one res_valid pulse, res_data = 33, res_valid 4 cycles after the last beat.
- Then STREAM len=2, (10,10), (1,1) -> res_data = 101, not 134; base subtraction holds despite the uncleared accumulator.
- LOAD len=3 with wgt 2,3,4, then REUSE len=4 with acts 1,1,1,1 -> no result for LOAD; pe_addr sequence 1,2,3,1; res_data = 11.
- STREAM len=2 with op_valid low for 3 cycles between beats, and res_ready held low 5 cycles -> res_data = expected product sum, stable while waiting; job_ready = 0 until the handshake.
- job_len = 0 in STREAM -> res_data = 0; the PE receives exactly one finish.
- rst asserted in RUN after 1 beat -> next cycle all outputs are at reset values with job_ready = 1; a following STREAM (3,3) job gives res_data = 9.

Source files
------------

// File: rtl/pe_seq_ctrl.sv
// rtl/pe_seq_ctrl.sv - operand/control sequencer and result collector for one weight-stationary MAC PE
//
// Purpose:
//   Accepts dot-product jobs (STREAM, LOAD, REUSE) and an operand stream.
//   It drives the PE's act/wgt/store/reuse/addr/finish inputs and returns
//   each STREAM/REUSE job's dot product on a valid/ready result port. The PE
//   accumulator is never cleared between jobs. The controller therefore
//   reports the difference between the current PE output and the previously
//   captured one.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (shared with PE)
//   job_valid/job_ready      job handshake; job_mode (0 STREAM, 1 LOAD, 2 REUSE,
//                            3 treated as STREAM), job_len (beats)
//   op_valid/op_ready        operand beat handshake; op_act, op_wgt
//   pe_act, pe_wgt, pe_store, pe_reuse, pe_addr, pe_finish
//                            registered drive to the PE
//   pe_out                   PE running-accumulator output
//   res_valid/res_ready      result handshake; res_data (registered)
//   perf_busy, perf_stall    only present when PE_SEQ_CTRL_PERF_EN is defined
//
// Optional feature macro: PE_SEQ_CTRL_PERF_EN (saturating busy/stall counters).

module pe_seq_ctrl #(
    parameter int IN_PRECISION  = 16,
    parameter int OUT_PRECISION = 32,
    parameter int REG_SIZE      = 4,
    parameter int LEN_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [1:0]               job_mode,
    input  logic [LEN_W-1:0]         job_len,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [IN_PRECISION-1:0]  op_act,
    input  logic [IN_PRECISION-1:0]  op_wgt,
    output logic [IN_PRECISION-1:0]  pe_act,
    output logic [IN_PRECISION-1:0]  pe_wgt,
    output logic                     pe_store,
    output logic                     pe_reuse,
    output logic [REG_SIZE-1:0]      pe_addr,
    output logic                     pe_finish,
    input  logic [OUT_PRECISION-1:0] pe_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OUT_PRECISION-1:0] res_data
`ifdef PE_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]              perf_busy,
    output logic [31:0]              perf_stall
`endif
);

    localparam logic [1:0] MODE_STREAM = 2'd0;
    localparam logic [1:0] MODE_LOAD   = 2'd1;
    localparam logic [1:0] MODE_REUSE  = 2'd2;

    // Weight slots are 1..REG_SIZE-1; slot 0 is the PE accumulator.
    localparam int                  IDX_MAX_I = REG_SIZE - 1;
    localparam logic [REG_SIZE-1:0] IDX_MAX   = IDX_MAX_I[REG_SIZE-1:0];
    localparam logic [REG_SIZE-1:0] IDX_ONE   = {{(REG_SIZE-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]    LOAD_MAX  = IDX_MAX_I[LEN_W-1:0];
    localparam logic [LEN_W-1:0]    LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN,
        S_WAIT,
        S_CAP,
        S_RES
    } state_t;

    state_t                   state;
    logic [1:0]               mode_r;
    logic [LEN_W-1:0]         cnt;
    logic [REG_SIZE-1:0]      idx;
    logic [OUT_PRECISION-1:0] base;

    assign job_ready = (state == S_IDLE);
    assign op_ready  = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_r    <= MODE_STREAM;
            cnt       <= '0;
            idx       <= IDX_ONE;
            base      <= '0;
            pe_act    <= '0;
            pe_wgt    <= '0;
            pe_store  <= 1'b0;
            pe_reuse  <= 1'b0;
            pe_addr   <= '0;
            pe_finish <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            // Operands default to zero so the PE adds nothing on idle or
            // bubble cycles; pe_addr deliberately keeps its last value.
            pe_act    <= '0;
            pe_wgt    <= '0;
            pe_store  <= 1'b0;
            pe_reuse  <= 1'b0;
            pe_finish <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        mode_r <= (job_mode == 2'd3) ? MODE_STREAM : job_mode;
                        idx    <= IDX_ONE;
                        if (job_len == '0) begin
                            if (job_mode == MODE_LOAD) begin
                                state <= S_IDLE;
                            end else begin
                                // Empty dot product still needs one finish
                                // so that base tracks the PE output.
                                pe_finish <= 1'b1;
                                state     <= S_FIN;
                            end
                        end else begin
                            // LOAD can only fill the weight slots once.
                            cnt   <= (job_mode == MODE_LOAD && job_len > LOAD_MAX)
                                     ? LOAD_MAX : job_len;
                            state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (op_valid) begin
                        case (mode_r)
                            MODE_LOAD: begin
                                // Act stays zero so the PE's concurrent MAC
                                // does not disturb the accumulator.
                                pe_store <= 1'b1;
                                pe_addr  <= idx;
                                pe_wgt   <= op_wgt;
                            end
                            MODE_REUSE: begin
                                pe_reuse <= 1'b1;
                                pe_addr  <= idx;
                                pe_act   <= op_act;
                            end
                            default: begin
                                pe_act <= op_act;
                                pe_wgt <= op_wgt;
                            end
                        endcase
                        idx <= (idx == IDX_MAX) ? IDX_ONE : idx + IDX_ONE;
                        cnt <= cnt - LEN_ONE;
                        if (cnt == LEN_ONE) begin
                            state <= (mode_r == MODE_LOAD) ? S_IDLE : S_DRAIN;
                        end
                    end
                end

                // Last beat is on the PE inputs; its MAC lands at the next edge,
                // so finish is raised only after it.
                S_DRAIN: begin
                    pe_finish <= 1'b1;
                    state     <= S_FIN;
                end

                // pe_finish is high for exactly this cycle; the PE registers
                // its accumulator onto pe_out at the closing edge.
                S_FIN: begin
                    state <= S_WAIT;
                end

                // pe_out has just updated; give it a full cycle to travel from
                // the PE before it is captured.
                S_WAIT: begin
                    state <= S_CAP;
                end

                S_CAP: begin
                    res_data  <= pe_out - base;
                    base      <= pe_out;
                    res_valid <= 1'b1;
                    state     <= S_RES;
                end

                S_RES: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PE_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (state != S_IDLE && perf_busy != '1) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (((state == S_RUN && !op_valid) || (state == S_RES && !res_ready))
                && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb/tb_pe_seq_ctrl.sv - scoreboard bench for pe_seq_ctrl with a behavioural MAC PE
module tb_pe_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [1:0]  job_mode;
    logic [7:0]  job_len;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_act;
    logic [15:0] op_wgt;
    logic [15:0] pe_act;
    logic [15:0] pe_wgt;
    logic        pe_store;
    logic        pe_reuse;
    logic [3:0]  pe_addr;
    logic        pe_finish;
    logic [31:0] pe_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    pe_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_mode  (job_mode),
        .job_len   (job_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_act    (op_act),
        .op_wgt    (op_wgt),
        .pe_act    (pe_act),
        .pe_wgt    (pe_wgt),
        .pe_store  (pe_store),
        .pe_reuse  (pe_reuse),
        .pe_addr   (pe_addr),
        .pe_finish (pe_finish),
        .pe_out    (pe_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural weight-stationary PE: MAC every edge, store into the
    // register file, finish copies the accumulator to out.
    logic [31:0] pe_acc;
    logic [15:0] pe_regs [0:3];
    always @(posedge clk) begin
        if (rst) begin
            pe_acc <= '0;
            pe_out <= '0;
            for (int i = 0; i < 4; i++) pe_regs[i] <= '0;
        end else begin
            pe_acc <= pe_acc + 32'(pe_act) * 32'(pe_reuse ? pe_regs[pe_addr[1:0]] : pe_wgt);
            if (pe_store) pe_regs[pe_addr[1:0]] <= pe_wgt;
            if (pe_finish) pe_out <= pe_acc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          rise;
    } exp_t;
    exp_t exp_q[$];

    // Result monitor: latency on the rising edge of res_valid, stability
    // while stalled, data on each handshake.
    logic        prev_valid = 1'b0;
    logic [31:0] held = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d, expected no result", res_data);
                end else if (exp_q[0].rise >= 0) begin
                    chk("res_latency_cycle", cyc, exp_q[0].rise);
                end
            end
            if (res_valid && prev_valid && !res_ready) chk("res_data_stable", res_data, held);
            if (res_valid && prev_valid) chk("res_data_stable_hs", res_data, held);
            if (res_valid && res_ready && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", res_data, e.data);
            end
            held = res_data;
        end
        prev_valid = res_valid;
    end

    // PE-side monitor.
    int         fin_count = 0;
    logic [3:0] addr_log[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (pe_finish) begin
                fin_count++;
                chk("fin_operands_zero", {pe_act, pe_wgt}, 32'd0);
            end
            if (pe_reuse) addr_log.push_back(pe_addr);
            if (pe_store || pe_reuse) begin
                checks++;
                if (pe_addr == 4'd0) begin
                    errors++;
                    $display("FAIL addr_zero_write: got %0d, expected nonzero", pe_addr);
                end
            end
            if (pe_store) chk("load_act_forced_zero", 32'(pe_act), 32'd0);
        end
    end

    logic [15:0] b_act [0:7];
    logic [15:0] b_wgt [0:7];
    int          b_gap [0:7];
    int          last_acc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [15:0] a, input logic [15:0] w, input int g);
        b_act[i] = a;
        b_wgt[i] = w;
        b_gap[i] = g;
    endtask

    task automatic send_job(input logic [1:0] m, input logic [7:0] l);
        int t = 0;
        job_valid = 1'b1;
        job_mode  = m;
        job_len   = l;
        while (!job_ready && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("job_accept_timeout", 32'(t), 32'd0);
        step();
        job_valid = 1'b0;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            op_valid = 1'b0;
            repeat (b_gap[i]) step();
            op_valid = 1'b1;
            op_act   = b_act[i];
            op_wgt   = b_wgt[i];
            while (!op_ready && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) chk("beat_accept_timeout", 32'(t), 32'd0);
            last_acc = cyc + 1;
            step();
        end
        op_valid = 1'b0;
        op_act   = '0;
        op_wgt   = '0;
    endtask

    task automatic push_exp(input logic [31:0] d, input int r);
        exp_t e;
        e.data = d;
        e.rise = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || !job_ready) && t < 200) begin
            step();
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_reset(input string name);
        chk({name, "_pe_act"},    32'(pe_act),    32'd0);
        chk({name, "_pe_wgt"},    32'(pe_wgt),    32'd0);
        chk({name, "_pe_store"},  32'(pe_store),  32'd0);
        chk({name, "_pe_reuse"},  32'(pe_reuse),  32'd0);
        chk({name, "_pe_addr"},   32'(pe_addr),   32'd0);
        chk({name, "_pe_finish"}, 32'(pe_finish), 32'd0);
        chk({name, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({name, "_res_data"},  res_data,       32'd0);
        chk({name, "_job_ready"}, 32'(job_ready), 32'd1);
        chk({name, "_op_ready"},  32'(op_ready),  32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int t;
        rst       = 1'b1;
        job_valid = 1'b0;
        job_mode  = 2'd0;
        job_len   = '0;
        op_valid  = 1'b0;
        op_act    = '0;
        op_wgt    = '0;
        res_ready = 1'b1;
        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;
        step();

        // STREAM 2*3 + 4*5 + 1*7 = 33
        set_beat(0, 16'd2, 16'd3, 0);
        set_beat(1, 16'd4, 16'd5, 0);
        set_beat(2, 16'd1, 16'd7, 0);
        send_job(2'd0, 8'd3);
        send_beats(3);
        push_exp(32'd33, last_acc + 4);
        wait_done("stream3");

        // STREAM 100 + 1 = 101 on top of an uncleared accumulator of 33
        set_beat(0, 16'd10, 16'd10, 0);
        set_beat(1, 16'd1,  16'd1,  0);
        send_job(2'd0, 8'd2);
        send_beats(2);
        push_exp(32'd101, last_acc + 4);
        wait_done("stream2");

        // LOAD weights 2,3,4 (acts offered nonzero but must be dropped)
        set_beat(0, 16'd9, 16'd2, 0);
        set_beat(1, 16'd9, 16'd3, 0);
        set_beat(2, 16'd9, 16'd4, 0);
        send_job(2'd1, 8'd3);
        send_beats(3);
        repeat (6) step();
        chk("load_no_result_job_ready", 32'(job_ready), 32'd1);

        // REUSE acts 1,1,1,1 over slots 1,2,3,1 -> 2+3+4+2 = 11
        addr_log.delete();
        for (int i = 0; i < 4; i++) set_beat(i, 16'd1, 16'd99, 0);
        send_job(2'd2, 8'd4);
        send_beats(4);
        push_exp(32'd11, last_acc + 4);
        wait_done("reuse4");
        chk("reuse_addr_count", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            chk("reuse_addr0", 32'(addr_log[0]), 32'd1);
            chk("reuse_addr1", 32'(addr_log[1]), 32'd2);
            chk("reuse_addr2", 32'(addr_log[2]), 32'd3);
            chk("reuse_addr3", 32'(addr_log[3]), 32'd1);
        end

        // STREAM with 3 bubbles and res_ready low 5 cycles: 3*4 + 5*6 = 42
        res_ready = 1'b0;
        set_beat(0, 16'd3, 16'd4, 0);
        set_beat(1, 16'd5, 16'd6, 3);
        send_job(2'd0, 8'd2);
        send_beats(2);
        push_exp(32'd42, last_acc + 4);
        t = 0;
        while (!res_valid && t < 50) begin
            step();
            t++;
        end
        chk("stall_res_valid_seen", 32'(res_valid), 32'd1);
        repeat (5) begin
            step();
            chk("stall_job_ready_low", 32'(job_ready), 32'd0);
            chk("stall_res_valid_held", 32'(res_valid), 32'd1);
        end
        res_ready = 1'b1;
        wait_done("stall");

        // Zero-length STREAM: result 0, exactly one finish
        f0 = fin_count;
        send_job(2'd0, 8'd0);
        push_exp(32'd0, -1);
        wait_done("len0");
        chk("len0_finish_count", 32'(fin_count - f0), 32'd1);

        // Reset in RUN after one beat
        set_beat(0, 16'd7, 16'd7, 0);
        send_job(2'd0, 8'd3);
        send_beats(1);
        rst = 1'b1;
        step();
        check_reset("midjob_reset");
        rst = 1'b0;
        step();
        set_beat(0, 16'd3, 16'd3, 0);
        send_job(2'd0, 8'd1);
        send_beats(1);
        push_exp(32'd9, last_acc + 4);
        wait_done("after_reset");

        // LOAD length 9 clipped to 3 slots, then REUSE 1*5 + 2*6 + 3*7 = 38
        set_beat(0, 16'd0, 16'd5, 0);
        set_beat(1, 16'd0, 16'd6, 0);
        set_beat(2, 16'd0, 16'd7, 0);
        send_job(2'd1, 8'd9);
        send_beats(3);
        op_valid = 1'b1;
        op_wgt   = 16'd1;
        chk("load_clip_op_ready", 32'(op_ready), 32'd0);
        chk("load_clip_job_ready", 32'(job_ready), 32'd1);
        op_valid = 1'b0;
        op_wgt   = '0;
        set_beat(0, 16'd1, 16'd0, 0);
        set_beat(1, 16'd2, 16'd0, 0);
        set_beat(2, 16'd3, 16'd0, 0);
        send_job(2'd2, 8'd3);
        send_beats(3);
        push_exp(32'd38, last_acc + 4);
        wait_done("reuse_after_clip");

        // Reserved mode behaves as STREAM: 6*7 = 42
        set_beat(0, 16'd6, 16'd7, 0);
        send_job(2'd3, 8'd1);
        send_beats(1);
        push_exp(32'd42, last_acc + 4);
        wait_done("reserved_mode");

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
